wide_mem: RTL and testbench

Parametrised byte-addressed, big-endian data memory for the node-state tables (sink flags, neighbour/cluster/battery/Q-value arrays). It generalises the fixed 16-bit word memory to a configurable word width, adds per-byte write enables, a registered read with a valid/ready handshake and bounds checking. A built-in fill engine initialises a region in hardware, replacing testbench-only preload. It sits between the routing/aggregation FSMs and storage.

---
 rtl/wide_mem_pkg.sv | 21 ++
 rtl/wide_mem_fill.sv | 85 ++++++++
 rtl/wide_mem.sv | 123 ++++++++++++
 tb/tb_wide_mem.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wide_mem_pkg.sv
// rtl/wide_mem_pkg.sv - shared types and constants for the wide node-state memory
package wide_mem_pkg;

   localparam int DEF_DEPTH      = 1024;
   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_WORD_BYTES = 2;
   localparam int BYTE_W         = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   // Base byte addresses of the node-state tables, in layout order
   localparam int NUM_TABLES = 12;
   localparam logic [15:0] TABLE_BASE [NUM_TABLES] = '{
      16'h0000, 16'h0008, 16'h0028, 16'h0048, 16'h00C8, 16'h0148,
      16'h01C8, 16'h0248, 16'h0648, 16'h0658, 16'h0700, 16'h0710
   };

endpackage

// File: rtl/wide_mem_fill.sv
// rtl/wide_mem_fill.sv - region fill engine: one full word per cycle from a latched base
module wide_mem_fill
   import wide_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int WORD_BYTES = DEF_WORD_BYTES,
   parameter int AW_EXT     = ADDR_W + 3
) (
   input  logic                         clock,
   input  logic                         nrst,
   input  logic                         fill_start,
   input  logic [ADDR_W-1:0]            fill_addr,
   input  logic [ADDR_W-1:0]            fill_len,
   input  logic [BYTE_W*WORD_BYTES-1:0] fill_data,
   output logic                         fill_busy,
   output logic                         fill_done,
   output logic                         wr_en,
   output logic [AW_EXT-1:0]            wr_addr,
   output logic [BYTE_W*WORD_BYTES-1:0] wr_data
);

   fill_state_t                  state, state_nx;
   logic [ADDR_W-1:0]            cnt;
   logic [ADDR_W-1:0]            len_q;
   logic [AW_EXT-1:0]            addr_q;
   logic [BYTE_W*WORD_BYTES-1:0] data_q;
   logic                         done_q, done_nx;
   logic                         load;

   // Address register is wider than ADDR_W so a long fill never wraps into low memory
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state  <= IDLE;
         cnt    <= '0;
         len_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= done_nx;
         if (load) begin
            cnt    <= '0;
            len_q  <= fill_len;
            addr_q <= AW_EXT'(fill_addr);
            data_q <= fill_data;
         end else if (state == FILL) begin
            cnt    <= cnt + ADDR_W'(1);
            addr_q <= addr_q + AW_EXT'(WORD_BYTES);
         end
      end
   end

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (fill_start) begin
               load = 1'b1;
               if (fill_len == '0) begin
                  done_nx = 1'b1;
               end else begin
                  state_nx = FILL;
               end
            end
         end
         FILL: begin
            if (cnt == len_q - ADDR_W'(1)) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign fill_busy = (state == FILL);
   assign fill_done = done_q;
   assign wr_en     = fill_busy;
   assign wr_addr   = addr_q;
   assign wr_data   = data_q;

endmodule

// File: rtl/wide_mem.sv
// rtl/wide_mem.sv - byte-addressed big-endian memory with byte enables, bounds check and fill
module wide_mem
   import wide_mem_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int WORD_BYTES = DEF_WORD_BYTES
) (
   input  logic                         clock,
   input  logic                         nrst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_wr,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [BYTE_W*WORD_BYTES-1:0] req_wdata,
   input  logic [WORD_BYTES-1:0]        req_be,
   output logic                         rsp_valid,
   output logic [BYTE_W*WORD_BYTES-1:0] rsp_rdata,
   output logic                         rsp_err,
   input  logic                         fill_start,
   input  logic [ADDR_W-1:0]            fill_addr,
   input  logic [ADDR_W-1:0]            fill_len,
   input  logic [BYTE_W*WORD_BYTES-1:0] fill_data,
   output logic                         fill_busy,
   output logic                         fill_done
);

   localparam int DW      = BYTE_W * WORD_BYTES;
   localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FILL_AW = ADDR_W + $clog2(WORD_BYTES + 1) + 1;

   logic [BYTE_W-1:0] mem [DEPTH];

   logic               req_fire;
   logic [ADDR_W:0]    req_last;
   logic               req_ok;
   logic [MEM_AW-1:0]  req_base;
   logic [DW-1:0]      rd_word;

   logic               fill_wr;
   logic [FILL_AW-1:0] fill_wr_addr;
   logic [DW-1:0]      fill_wr_data;
   logic [FILL_AW:0]   fill_last;
   logic               fill_ok;
   logic [MEM_AW-1:0]  fill_base;

   logic [WORD_BYTES-1:0] wr_lane;
   logic [MEM_AW-1:0]     wr_base;
   logic [DW-1:0]         wr_data;

   wide_mem_fill #(
      .ADDR_W     (ADDR_W),
      .WORD_BYTES (WORD_BYTES),
      .AW_EXT     (FILL_AW)
   ) u_fill (
      .clock      (clock),
      .nrst       (nrst),
      .fill_start (fill_start),
      .fill_addr  (fill_addr),
      .fill_len   (fill_len),
      .fill_data  (fill_data),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .wr_en      (fill_wr),
      .wr_addr    (fill_wr_addr),
      .wr_data    (fill_wr_data)
   );

   assign req_ready = !fill_busy;
   assign req_fire  = req_valid && req_ready;

   // Range checks use one extra bit so the last byte of a word can never wrap to address 0
   assign req_last  = {1'b0, req_addr} + (ADDR_W+1)'(WORD_BYTES - 1);
   assign req_ok    = req_last < (ADDR_W+1)'(DEPTH);
   assign req_base  = req_addr[MEM_AW-1:0];

   assign fill_last = {1'b0, fill_wr_addr} + (FILL_AW+1)'(WORD_BYTES - 1);
   assign fill_ok   = fill_last < (FILL_AW+1)'(DEPTH);
   assign fill_base = fill_wr_addr[MEM_AW-1:0];

   // Requests are only accepted while the fill engine is idle, so the two never collide
   always_comb begin
      wr_lane = '0;
      wr_base = req_base;
      wr_data = req_wdata;
      if (req_fire && req_wr && req_ok) begin
         wr_lane = req_be;
      end else if (fill_wr && fill_ok) begin
         wr_lane = '1;
         wr_base = fill_base;
         wr_data = fill_wr_data;
      end
   end

   // Lane k is byte address base+k and the k-th byte from the top of the word
   always_ff @(posedge clock) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
         if (wr_lane[WORD_BYTES-1-k]) begin
            mem[wr_base + MEM_AW'(k)] <= wr_data[DW-1-BYTE_W*k -: BYTE_W];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
         rd_word[DW-1-BYTE_W*k -: BYTE_W] = mem[req_base + MEM_AW'(k)];
      end
   end

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= req_fire;
         rsp_err   <= req_fire && !req_ok;
         rsp_rdata <= (req_fire && !req_wr && req_ok) ? rd_word : '0;
      end
   end

endmodule

// File: tb/tb_wide_mem.sv
// tb/tb_wide_mem.sv - self-checking bench for wide_mem with a byte-array reference model
module tb_wide_mem;

   localparam int DEPTH = 1024;
   localparam int WB    = 2;

   logic        clock = 1'b0;
   logic        nrst;
   logic        req_valid, req_ready, req_wr;
   logic [15:0] req_addr, req_wdata;
   logic [1:0]  req_be;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic        fill_start;
   logic [15:0] fill_addr, fill_len, fill_data;
   logic        fill_busy, fill_done;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   wide_mem #(.DEPTH(DEPTH), .ADDR_W(16), .WORD_BYTES(WB)) dut (
      .clock(clock), .nrst(nrst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .fill_start(fill_start), .fill_addr(fill_addr), .fill_len(fill_len),
      .fill_data(fill_data), .fill_busy(fill_busy), .fill_done(fill_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain byte array plus a word-by-word fill progress counter
   logic [7:0]  mm [DEPTH];
   bit          m_busy = 0;
   int          m_i, m_len, m_base;
   logic [15:0] m_data;
   logic        e_valid = 0, e_err = 0, e_done = 0;
   logic [15:0] e_rdata = 0;

   always @(posedge clock) begin : model
      int a;
      if (!nrst) begin
         m_busy = 0; e_valid = 0; e_err = 0; e_done = 0; e_rdata = 0;
      end else begin
         e_valid = 0; e_err = 0; e_done = 0; e_rdata = 0;
         if (req_valid && !m_busy) begin
            a = int'(req_addr);
            e_valid = 1;
            if (a + WB - 1 >= DEPTH) e_err = 1;
            else if (req_wr) begin
               for (int k = 0; k < WB; k++)
                  if (req_be[WB-1-k]) mm[a+k] = req_wdata[15-8*k -: 8];
            end else begin
               for (int k = 0; k < WB; k++) e_rdata[15-8*k -: 8] = mm[a+k];
            end
         end
         if (m_busy) begin
            a = m_base + m_i * WB;
            if (a + WB - 1 < DEPTH)
               for (int k = 0; k < WB; k++) mm[a+k] = m_data[15-8*k -: 8];
            m_i++;
            if (m_i == m_len) begin m_busy = 0; e_done = 1; end
         end else if (fill_start) begin
            if (fill_len == 0) e_done = 1;
            else begin
               m_busy = 1; m_i = 0; m_len = int'(fill_len);
               m_base = int'(fill_addr); m_data = fill_data;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (!nrst) begin
         chk("rst_rsp_valid", rsp_valid, 64'd0);
         chk("rst_rsp_rdata", rsp_rdata, 64'd0);
         chk("rst_rsp_err", rsp_err, 64'd0);
         chk("rst_fill_busy", fill_busy, 64'd0);
         chk("rst_fill_done", fill_done, 64'd0);
         chk("rst_req_ready", req_ready, 64'd1);
      end else begin
         chk("rsp_valid", rsp_valid, e_valid);
         chk("rsp_rdata", rsp_rdata, e_rdata);
         chk("rsp_err", rsp_err, e_err);
         chk("fill_busy", fill_busy, m_busy);
         chk("fill_done", fill_done, e_done);
         chk("req_ready", req_ready, !m_busy);
      end
   end

   task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [1:0] be, output logic v, output logic [15:0] rd,
                         output logic e);
      @(negedge clock);
      req_valid = 1; req_wr = wr; req_addr = a; req_wdata = wd; req_be = be;
      @(negedge clock);
      req_valid = 0;
      v = rsp_valid; rd = rsp_rdata; e = rsp_err;
   endtask

   task automatic do_fill(input logic [15:0] a, input logic [15:0] len, input logic [15:0] d,
                          output int cyc, output logic done);
      @(negedge clock);
      fill_start = 1; fill_addr = a; fill_len = len; fill_data = d;
      @(negedge clock);
      fill_start = 0;
      cyc = 0;
      while (fill_busy && cyc < 2000) begin
         cyc++;
         @(negedge clock);
      end
      done = fill_done;
   endtask

   initial begin
      logic        v, e, dn;
      logic [15:0] rd;
      int          cyc;

      nrst = 0; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_be = 0;
      fill_start = 0; fill_addr = 0; fill_len = 0; fill_data = 0;
      repeat (2) @(negedge clock);
      #2 nrst = 1;

      do_fill(16'h0000, 16'd512, 16'h5A3C, cyc, dn);
      chk("init_fill_cycles", cyc, 64'd512);
      chk("init_fill_done", dn, 64'd1);

      // Reset asserted mid-cycle while a response is on the outputs
      @(negedge clock);
      req_valid = 1; req_wr = 0; req_addr = 16'h0010; req_be = 2'b11;
      @(negedge clock);
      req_valid = 0;
      chk("pre_rst_valid", rsp_valid, 64'd1);
      #1 nrst = 0;
      #1;
      chk("async_rst_valid", rsp_valid, 64'd0);
      chk("async_rst_rdata", rsp_rdata, 64'd0);
      chk("async_rst_ready", req_ready, 64'd1);
      @(negedge clock);
      #2 nrst = 1;

      // Write then read-after-write back to back, then unaligned read
      @(negedge clock);
      req_valid = 1; req_wr = 1; req_addr = 16'h0049; req_wdata = 16'hABCD; req_be = 2'b11;
      @(negedge clock);
      req_wr = 0; req_addr = 16'h0049;
      chk("wr_ack_valid", rsp_valid, 64'd1);
      @(negedge clock);
      req_addr = 16'h004A;
      chk("raw_rdata", rsp_rdata, 64'hABCD);
      chk("raw_err", rsp_err, 64'd0);
      @(negedge clock);
      req_valid = 0;
      chk("unaligned_rdata", rsp_rdata, 64'hCD3C);

      // Byte enables and the be=0 no-op
      do_req(1, 16'h0100, 16'h1234, 2'b11, v, rd, e);
      do_req(1, 16'h0100, 16'hFFFF, 2'b01, v, rd, e);
      do_req(0, 16'h0100, 16'h0000, 2'b11, v, rd, e);
      chk("be_low_rdata", rd, 64'h12FF);
      do_req(1, 16'h0100, 16'hDEAD, 2'b00, v, rd, e);
      chk("be_zero_ack", v, 64'd1);
      do_req(0, 16'h0100, 16'h0000, 2'b11, v, rd, e);
      chk("be_zero_unchanged", rd, 64'h12FF);

      // Bounds
      do_req(1, 16'h03FF, 16'hABCD, 2'b11, v, rd, e);
      chk("oob_wr_err", e, 64'd1);
      do_req(0, 16'h03FE, 16'h0000, 2'b11, v, rd, e);
      chk("last_word_err", e, 64'd0);
      chk("last_word_rdata", rd, 64'h5A3C);
      do_req(0, 16'h03FF, 16'h0000, 2'b11, v, rd, e);
      chk("oob_rd_err", e, 64'd1);
      chk("oob_rd_rdata", rd, 64'h0000);
      do_req(1, 16'hFFFF, 16'h1111, 2'b11, v, rd, e);
      chk("wrap_wr_err", e, 64'd1);
      do_req(0, 16'h0000, 16'h0000, 2'b11, v, rd, e);
      chk("no_wrap_byte0", rd, 64'h5A3C);

      // Table fill
      do_fill(16'h0008, 16'd16, 16'h0000, cyc, dn);
      chk("fill16_cycles", cyc, 64'd16);
      chk("fill16_done", dn, 64'd1);
      for (int i = 0; i < 16; i++) begin
         do_req(0, 16'h0008 + 16'(2*i), 16'h0000, 2'b11, v, rd, e);
         chk("fill16_word", rd, 64'h0000);
      end
      do_req(0, 16'h0028, 16'h0000, 2'b11, v, rd, e);
      chk("fill16_after_end", rd, 64'h5A3C);

      do_fill(16'h0300, 16'd0, 16'h1111, cyc, dn);
      chk("fill0_cycles", cyc, 64'd0);
      chk("fill0_done", dn, 64'd1);
      do_req(0, 16'h0300, 16'h0000, 2'b11, v, rd, e);
      chk("fill0_no_write", rd, 64'h5A3C);

      // Fill crossing the top of memory: last two words skipped
      do_fill(16'h03FC, 16'd4, 16'hBEEF, cyc, dn);
      chk("fill_oob_cycles", cyc, 64'd4);
      do_req(0, 16'h03FE, 16'h0000, 2'b11, v, rd, e);
      chk("fill_oob_last", rd, 64'hBEEF);

      // Collision of fill_start and read, then reset after five fill words
      @(negedge clock);
      fill_start = 1; fill_addr = 16'h0200; fill_len = 16'd8; fill_data = 16'h7777;
      req_valid = 1; req_wr = 0; req_addr = 16'h0200; req_be = 2'b11;
      @(negedge clock);
      fill_start = 0; req_valid = 0;
      chk("coll_rdata", rsp_rdata, 64'h5A3C);
      chk("coll_busy", fill_busy, 64'd1);
      repeat (5) @(negedge clock);
      #1 nrst = 0;
      #1;
      chk("midfill_rst_busy", fill_busy, 64'd0);
      chk("midfill_rst_ready", req_ready, 64'd1);
      @(negedge clock);
      #2 nrst = 1;
      for (int i = 0; i < 8; i++) begin
         do_req(0, 16'h0200 + 16'(2*i), 16'h0000, 2'b11, v, rd, e);
         chk("midfill_word", rd, (i < 5) ? 64'h7777 : 64'h5A3C);
      end

      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
